// File: rtl/row_scan_sequencer.sv
// Row scan controller: steps a 3-bit decoder select through the enabled rows of
// an 8-bit mask in ascending order, holding each row for a programmable dwell.
module row_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [7:0]         row_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         sel_reg, sel_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [7:0]         mask_reg, mask_next;
    logic [DWELL_W-1:0] dlast_reg, dlast_next;
    logic               mode_reg, mode_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;

    logic               has_higher;
    logic [2:0]         next_row;
    logic [2:0]         in_low;
    logic [DWELL_W-1:0] dwell_m1;

    // The counter holds the remaining cycles minus one, so dwell 0 and 1 both give one cycle.
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // Descending loops: the last hit is the lowest qualifying row.
    always_comb begin
        has_higher = 1'b0;
        next_row   = 3'd0;
        in_low     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_reg[i] && (3'(i) > sel_reg)) begin
                has_higher = 1'b1;
                next_row   = 3'(i);
            end
            if (row_mask[i]) begin
                in_low = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        mask_next  = mask_reg;
        dlast_next = dlast_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                sel_next   = 3'd0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
                if (start && !stop && (row_mask != 8'd0)) begin
                    state_next = SCAN;
                    mask_next  = row_mask;
                    dlast_next = dwell_m1;
                    mode_next  = mode_cont;
                    sel_next   = in_low;
                    cnt_next   = dwell_m1;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_next = IDLE;
                    sel_next   = 3'd0;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end else if (cnt_reg == '0) begin
                    if (has_higher) begin
                        sel_next = next_row;
                        cnt_next = dlast_reg;
                    end else begin
                        done_next = 1'b1;
                        if (mode_reg && (row_mask != 8'd0)) begin
                            // Wrap: new frame picks up the live mask and dwell.
                            mask_next  = row_mask;
                            dlast_next = dwell_m1;
                            sel_next   = in_low;
                            cnt_next   = dwell_m1;
                        end else begin
                            state_next = IDLE;
                            sel_next   = 3'd0;
                            valid_next = 1'b0;
                            busy_next  = 1'b0;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 3'd0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 3'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mask_reg  <= 8'd0;
            dlast_reg <= '0;
            mode_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            mask_reg  <= mask_next;
            dlast_reg <= dlast_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign sel        = sel_reg;
    assign sel_valid  = valid_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer: expected per-cycle outputs are queued
// as stimulus is applied and compared one entry per clock.
module tb_row_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] row_mask = 8'd0;
    logic [7:0] dwell = 8'd0;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    row_scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .row_mask(row_mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected {sel, sel_valid, busy, frame_done} for one upcoming cycle.
    task automatic push(input int s, input bit v, input bit b, input bit fd);
        exp_q.push_back({3'(s), v, b, fd});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        logic [5:0] e;
        logic [5:0] o;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = {sel, sel_valid, busy, frame_done};
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed sel/v/b/fd=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                       tag, o[5:3], o[2], o[1], o[0], e[5:3], e[2], e[1], e[0]);
            end
            $display("cycle %s sel=%0d v=%b busy=%b fd=%b", tag, o[5:3], o[2], o[1], o[0]);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [5:0] o;
        o = {sel, sel_valid, busy, frame_done};
        checks++;
        assert (o === 6'd0) else begin
            failures++;
            $error("FAIL %s observed %b expected 000000", tag, o);
        end
        $display("check %s outputs=%b", tag, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #12;
        check_zero("reset_init");
        @(negedge clk);
        rst = 1'b0;
        push_idle(2);
        drain("post_reset_idle");

        // Async reset while scanning row 4
        row_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        for (int r = 0; r <= 4; r++) begin
            push(r, 1, 1, 0);
            if (r < 4) push(r, 1, 1, 0);
        end
        drain("pre_reset_scan");
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        push_idle(4);
        drain("idle_after_reset");

        // One-shot full mask, dwell 2
        row_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        for (int i = 0; i < 16; i++) push(i / 2, 1, 1, 0);
        push(0, 0, 0, 1);
        push_idle(2);
        drain("oneshot_ff");

        // Sparse mask, zero dwell
        row_mask = 8'b1010_0100; dwell = 8'd0; start = 1'b1;
        push(2, 1, 1, 0); push(5, 1, 1, 0); push(7, 1, 1, 0);
        push(0, 0, 0, 1);
        push_idle(1);
        drain("sparse_dwell0");

        // Continuous 8'h81, dwell 3
        row_mask = 8'h81; dwell = 8'd3; mode_cont = 1'b1; start = 1'b1;
        push(0, 1, 1, 0); push(0, 1, 1, 0); push(0, 1, 1, 0);
        push(7, 1, 1, 0); push(7, 1, 1, 0); push(7, 1, 1, 0);
        push(0, 1, 1, 1); push(0, 1, 1, 0); push(0, 1, 1, 0);
        push(7, 1, 1, 0);
        drain("cont_81");
        row_mask = 8'h02;
        mode_cont = 1'b0;
        push(7, 1, 1, 0); push(7, 1, 1, 0);
        push(1, 1, 1, 1); push(1, 1, 1, 0); push(1, 1, 1, 0);
        push(1, 1, 1, 1); push(1, 1, 1, 0);
        drain("cont_02");
        row_mask = 8'h00;
        push(1, 1, 1, 0);
        push(0, 0, 0, 1);
        push_idle(3);
        drain("cont_to_zero");

        // Stop together with start during row 3
        row_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        push(0, 1, 1, 0); push(0, 1, 1, 0); push(1, 1, 1, 0); push(1, 1, 1, 0);
        push(2, 1, 1, 0); push(2, 1, 1, 0); push(3, 1, 1, 0);
        drain("stop_pre");
        stop = 1'b1; start = 1'b1;
        push(0, 0, 0, 0);
        drain("stop_edge");
        stop = 1'b0;
        push_idle(3);
        drain("stop_after");

        // Start with empty mask is ignored
        row_mask = 8'h00; dwell = 8'd1; start = 1'b1;
        push_idle(10);
        drain("empty_mask");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
